// File: rtl/regfile_writeback_if.sv
// Interface: regfile_writeback_if
// Bundles the pipeline writeback (P), long-latency result (L), register-file
// write port, pending mask and bypass lookup signals of regfile_writeback.
// master = producer / consumer side (pipeline, L unit, decode)
// slave  = the writeback merger itself
interface regfile_writeback_if;
   logic        p_valid;
   logic [4:0]  p_dest;
   logic [31:0] p_data;
   logic        p_ready;
   logic        l_valid;
   logic [4:0]  l_dest;
   logic [31:0] l_data;
   logic        l_ready;
   logic        writeEnable;
   logic [4:0]  dest;
   logic [31:0] writeData;
   logic [31:0] pending;
   logic [4:0]  byp_src;
   logic        byp_hit;
   logic [31:0] byp_data;

   modport master (
      output p_valid, p_dest, p_data, l_valid, l_dest, l_data, byp_src,
      input  p_ready, l_ready, writeEnable, dest, writeData, pending, byp_hit, byp_data
   );

   modport slave (
      input  p_valid, p_dest, p_data, l_valid, l_dest, l_data, byp_src,
      output p_ready, l_ready, writeEnable, dest, writeData, pending, byp_hit, byp_data
   );
endinterface

// File: rtl/regfile_writeback.sv
// Module: regfile_writeback
// Merges the in-order pipeline writeback (P) and the long-latency result
// stream (L) onto the single register-file write port. L results wait in a
// small FIFO; x0 writes are dropped; a starvation counter forces L ahead of P
// after STARVE_LIMIT lost cycles; a pending mask flags every register with an
// outstanding write.
// Optional feature macro: WB_BYPASS_EN (youngest in-flight value lookup).
module regfile_writeback #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input logic                clk,
   input logic                rst,
   regfile_writeback_if.slave wb
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [4:0]    fifo_dest [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [SW-1:0] starve_cnt;
   logic          empty;
   logic          full;
   logic          grant_l;
   logic          grant_p;
   logic          enq;
   logic [31:0]   pend;

   // Arbitration works from registered FIFO state only, so a result enqueued
   // into an empty FIFO cannot be granted in the same cycle.
   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign grant_l = !empty && (!wb.p_valid || (wb.p_dest == 5'd0) || (starve_cnt == STARVE_MAX));
   assign grant_p = wb.p_valid && (wb.p_dest != 5'd0) && !grant_l;
   assign enq     = wb.l_valid && !full && (wb.l_dest != 5'd0);

   assign wb.p_ready = !grant_l;
   assign wb.l_ready = !full;

   // FIFO payload storage; contents are meaningless outside the head..tail window so no reset
   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_dest[tail] <= wb.l_dest;
         fifo_data[tail] <= wb.l_data;
      end
   end

   // FIFO pointers and occupancy; a full FIFO refuses L even when it is dequeuing this cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            tail <= tail + PW'(1);
         end
         if (grant_l) begin
            head <= head + PW'(1);
         end
         count <= count + CW'(enq) - CW'(grant_l);
      end
   end

   // Count the cycles the FIFO head is passed over, saturating at the limit that forces L through
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (empty || grant_l) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   // Registered write port: winner of this cycle's grant is written next cycle, address/data hold when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb.writeEnable <= 1'b0;
         wb.dest        <= 5'd0;
         wb.writeData   <= 32'd0;
      end else if (grant_l) begin
         wb.writeEnable <= 1'b1;
         wb.dest        <= fifo_dest[head];
         wb.writeData   <= fifo_data[head];
      end else if (grant_p) begin
         wb.writeEnable <= 1'b1;
         wb.dest        <= wb.p_dest;
         wb.writeData   <= wb.p_data;
      end else begin
         wb.writeEnable <= 1'b0;
      end
   end

   // Pending mask: every live FIFO entry plus the output stage while it is writing
   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count) begin
            pend[fifo_dest[head + PW'(i)]] = 1'b1;
         end
      end
      if (wb.writeEnable) begin
         pend[wb.dest] = 1'b1;
      end
      pend[0] = 1'b0;
   end

   assign wb.pending = pend;

`ifdef WB_BYPASS_EN
   logic        byp_hit_c;
   logic [31:0] byp_data_c;

   // Bypass lookup scanning oldest to youngest so the youngest match (FIFO tail) wins
   always_comb begin
      byp_hit_c  = 1'b0;
      byp_data_c = '0;
      if (wb.writeEnable && (wb.dest == wb.byp_src)) begin
         byp_hit_c  = 1'b1;
         byp_data_c = wb.writeData;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < count) && (fifo_dest[head + PW'(i)] == wb.byp_src)) begin
            byp_hit_c  = 1'b1;
            byp_data_c = fifo_data[head + PW'(i)];
         end
      end
      if (wb.byp_src == 5'd0) begin
         byp_hit_c  = 1'b0;
         byp_data_c = '0;
      end
   end

   assign wb.byp_hit  = byp_hit_c;
   assign wb.byp_data = byp_data_c;
`else
   logic unused_byp_src;

   assign unused_byp_src = ^wb.byp_src;
   assign wb.byp_hit     = 1'b0;
   assign wb.byp_data    = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Testbench: tb_regfile_writeback
// Directed scenarios plus a randomized run, all checked against a queue-based
// reference model of the writeback merger. Honours WB_BYPASS_EN if defined.
module tb_regfile_writeback;
   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   regfile_writeback_if wb();

   regfile_writeback #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb.slave)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   typedef struct packed {
      logic [4:0]  d;
      logic [31:0] v;
   } ent_t;

   // Reference model: FIFO as a queue, starvation as an integer, last write held
   ent_t        mq[$];
   int          m_starve;
   logic        m_we;
   logic [4:0]  m_dest;
   logic [31:0] m_data;

   // Watchdog so the run always terminates
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic bit m_gl();
      return (mq.size() != 0) && (!wb.p_valid || (wb.p_dest == 5'd0) || (m_starve == STARVE_LIMIT));
   endfunction

   function automatic logic [31:0] m_pending();
      logic [31:0] r;
      r = '0;
      foreach (mq[k]) r[mq[k].d] = 1'b1;
      if (m_we) r[m_dest] = 1'b1;
      r[0] = 1'b0;
      return r;
   endfunction

   task automatic m_byp(input logic [4:0] s, output logic h, output logic [31:0] d);
      h = 1'b0;
      d = '0;
`ifdef WB_BYPASS_EN
      if (s != 5'd0) begin
         if (m_we && (m_dest == s)) begin h = 1'b1; d = m_data; end
         foreach (mq[k]) if (mq[k].d == s) begin h = 1'b1; d = mq[k].v; end
      end
`endif
   endtask

   task automatic model_reset();
      mq.delete();
      m_starve = 0;
      m_we     = 1'b0;
      m_dest   = '0;
      m_data   = '0;
   endtask

   // Sample inputs before the edge, advance the model at the edge, return 1 time unit later
   task automatic tick();
      bit   gl, gp, lacc;
      int   pre;
      ent_t e;
      pre  = mq.size();
      gl   = m_gl();
      gp   = wb.p_valid && (wb.p_dest != 5'd0) && !gl;
      lacc = wb.l_valid && (pre < DEPTH) && (wb.l_dest != 5'd0);
      e    = '{d: wb.l_dest, v: wb.l_data};
      @(posedge clk);
      if (gl) begin
         m_we = 1'b1; m_dest = mq[0].d; m_data = mq[0].v;
         void'(mq.pop_front());
      end else if (gp) begin
         m_we = 1'b1; m_dest = wb.p_dest; m_data = wb.p_data;
      end else begin
         m_we = 1'b0;
      end
      if (lacc) mq.push_back(e);
      if ((pre == 0) || gl) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
      #1;
   endtask

   task automatic idle_inputs();
      wb.p_valid = 1'b0; wb.p_dest = '0; wb.p_data = '0;
      wb.l_valid = 1'b0; wb.l_dest = '0; wb.l_data = '0;
      wb.byp_src = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      #12;
      compared++; if (wb.writeEnable !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we: got %b expected 0", wb.writeEnable); end
      compared++; if (wb.dest !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_dest: got %0d expected 0", wb.dest); end
      compared++; if (wb.writeData !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_data: got %h expected 0", wb.writeData); end
      compared++; if (wb.l_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_lready: got %b expected 1", wb.l_ready); end
      compared++; if (wb.p_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_pready: got %b expected 1", wb.p_ready); end
      compared++; if (wb.pending !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_pending: got %h expected 0", wb.pending); end
      compared++; if (wb.byp_hit !== 1'b0 || wb.byp_data !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_bypass: got %b/%h expected 0/0", wb.byp_hit, wb.byp_data); end
      @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_p_only();
      do_reset();
      wb.p_valid = 1'b1; wb.p_dest = 5'd5; wb.p_data = 32'hDEADBEEF;
      #1;
      compared++; if (wb.p_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL p_only_ready: got %b expected 1", wb.p_ready); end
      tick();
      wb.p_valid = 1'b0;
      compared++; if (wb.writeEnable !== 1'b1 || wb.dest !== 5'd5 || wb.writeData !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL p_only_write: got %b/%0d/%h expected 1/5/deadbeef", wb.writeEnable, wb.dest, wb.writeData); end
      compared++; if (wb.pending !== 32'h20) begin mismatched++; $display("[TB] FAIL p_only_pending: got %h expected 00000020", wb.pending); end
      #1;
      tick();
      compared++; if (wb.writeEnable !== 1'b0 || wb.dest !== 5'd5 || wb.writeData !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL p_only_idle: got %b/%0d/%h expected 0/5/deadbeef", wb.writeEnable, wb.dest, wb.writeData); end
      compared++; if (wb.pending !== 32'h0) begin mismatched++; $display("[TB] FAIL p_only_pending_idle: got %h expected 0", wb.pending); end
   endtask

   task automatic test_x0_drop();
      do_reset();
      wb.p_valid = 1'b1; wb.p_dest = 5'd0; wb.p_data = 32'h1234_5678;
      #1;
      compared++; if (wb.p_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL x0_p_ready: got %b expected 1", wb.p_ready); end
      tick();
      wb.p_valid = 1'b0;
      wb.l_valid = 1'b1; wb.l_dest = 5'd0; wb.l_data = 32'h8765_4321;
      #1;
      compared++; if (wb.l_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL x0_l_ready: got %b expected 1", wb.l_ready); end
      tick();
      wb.l_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         compared++; if (wb.writeEnable !== 1'b0 || wb.pending !== 32'd0) begin mismatched++; $display("[TB] FAIL x0_no_write: got we=%b pending=%h expected 0/0", wb.writeEnable, wb.pending); end
         #1;
         tick();
      end
   endtask

   task automatic test_fifo_full();
      logic [4:0]  got_d[$];
      logic [31:0] got_v[$];
      bit          lacc;
      do_reset();
      wb.p_valid = 1'b1; wb.p_dest = 5'd9; wb.p_data = 32'h9000_0000;
      for (int j = 1; j <= 4; j++) begin
         wb.l_valid = 1'b1; wb.l_dest = 5'(j); wb.l_data = 32'hA0 + 32'(j);
         #1;
         compared++; if (wb.l_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL full_lready_open%0d: got %b expected 1", j, wb.l_ready); end
         tick();
      end
      wb.l_dest = 5'd5; wb.l_data = 32'hA5;
      #1;
      compared++; if (wb.l_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL full_lready_closed: got %b expected 0", wb.l_ready); end
      // FIFO holds 1..4 and the output stage is writing P's dest 9
      compared++; if (wb.pending !== 32'h21E) begin mismatched++; $display("[TB] FAIL full_pending: got %h expected 0000021e", wb.pending); end
      for (int c = 0; c < 200 && got_d.size() < 5; c++) begin
         wb.p_data = 32'h9000_0001 + 32'(c);
         if (c > 0) #1;
         lacc = wb.l_valid && (mq.size() < DEPTH);
         tick();
         if (lacc) wb.l_valid = 1'b0;
         compared++; if (wb.writeEnable !== m_we || wb.dest !== m_dest || wb.writeData !== m_data) begin mismatched++; $display("[TB] FAIL full_drain_write: got %b/%0d/%h expected %b/%0d/%h", wb.writeEnable, wb.dest, wb.writeData, m_we, m_dest, m_data); end
         if (wb.writeEnable && wb.dest != 5'd9) begin got_d.push_back(wb.dest); got_v.push_back(wb.writeData); end
      end
      compared++;
      if (got_d.size() != 5) begin
         mismatched++; $display("[TB] FAIL full_drain_timeout: got %0d L writes expected 5", got_d.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            if (got_d[k] !== 5'(k + 1) || got_v[k] !== 32'hA1 + 32'(k)) begin
               mismatched++; $display("[TB] FAIL full_drain_order: entry %0d got %0d/%h expected %0d/%h", k, got_d[k], got_v[k], k + 1, 32'hA1 + 32'(k));
               break;
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_starvation();
      do_reset();
      wb.p_valid = 1'b1; wb.p_dest = 5'd9; wb.p_data = 32'h5000_0000;
      wb.l_valid = 1'b1; wb.l_dest = 5'd7; wb.l_data = 32'h0000_0777;
      #1;
      tick();
      wb.l_valid = 1'b0;
      for (int k = 0; k < STARVE_LIMIT; k++) begin
         wb.p_data = 32'h5000_0001 + 32'(k);
         #1;
         compared++; if (wb.p_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL starve_p_wins%0d: got p_ready %b expected 1", k, wb.p_ready); end
         tick();
         compared++; if (wb.writeEnable !== 1'b1 || wb.dest !== 5'd9 || wb.writeData !== 32'h5000_0001 + 32'(k)) begin mismatched++; $display("[TB] FAIL starve_p_write%0d: got %b/%0d/%h expected 1/9/%h", k, wb.writeEnable, wb.dest, wb.writeData, 32'h5000_0001 + 32'(k)); end
      end
      #1;
      compared++; if (wb.p_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL starve_forced: got p_ready %b expected 0", wb.p_ready); end
      tick();
      compared++; if (wb.writeEnable !== 1'b1 || wb.dest !== 5'd7 || wb.writeData !== 32'h0000_0777) begin mismatched++; $display("[TB] FAIL starve_l_write: got %b/%0d/%h expected 1/7/00000777", wb.writeEnable, wb.dest, wb.writeData); end
      #1;
      compared++; if (wb.p_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL starve_after: got p_ready %b expected 1", wb.p_ready); end
      idle_inputs();
      #1;
      tick();
   endtask

   task automatic test_reset_midrun();
      do_reset();
      wb.p_valid = 1'b1; wb.p_dest = 5'd9; wb.p_data = 32'h6000_0000;
      for (int j = 2; j <= 4; j++) begin
         wb.l_valid = 1'b1; wb.l_dest = 5'(j); wb.l_data = 32'h60 + 32'(j);
         #1;
         tick();
      end
      wb.l_valid = 1'b0;
      #1;
      compared++; if (wb.pending !== 32'h21C) begin mismatched++; $display("[TB] FAIL midrun_pending_before: got %h expected 0000021c", wb.pending); end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      compared++; if (wb.writeEnable !== 1'b0 || wb.pending !== 32'd0 || wb.l_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midrun_async: got we=%b pending=%h l_ready=%b expected 0/0/1", wb.writeEnable, wb.pending, wb.l_ready); end
      idle_inputs();
      @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int c = 0; c < 10; c++) begin
         compared++; if (wb.writeEnable !== 1'b0 || wb.pending !== 32'd0) begin mismatched++; $display("[TB] FAIL midrun_stale: got we=%b dest=%0d pending=%h expected 0/-/0", wb.writeEnable, wb.dest, wb.pending); end
         #1;
         tick();
      end
   endtask

   task automatic test_bypass();
      logic        eh;
      logic [31:0] ed;
      do_reset();
      wb.p_valid = 1'b1; wb.p_dest = 5'd9; wb.p_data = 32'h99;
      wb.l_valid = 1'b1; wb.l_dest = 5'd3; wb.l_data = 32'd1;
      #1;
      tick();
      wb.l_data = 32'd2;
      #1;
      tick();
      wb.l_valid = 1'b0;
      wb.byp_src = 5'd3;
      #1;
`ifdef WB_BYPASS_EN
      eh = 1'b1; ed = 32'd2;
`else
      eh = 1'b0; ed = 32'd0;
`endif
      compared++; if (wb.byp_hit !== eh || wb.byp_data !== ed) begin mismatched++; $display("[TB] FAIL bypass_youngest: got %b/%h expected %b/%h", wb.byp_hit, wb.byp_data, eh, ed); end
      wb.byp_src = 5'd9;
      #1;
`ifdef WB_BYPASS_EN
      eh = 1'b1; ed = 32'h99;
`else
      eh = 1'b0; ed = 32'd0;
`endif
      compared++; if (wb.byp_hit !== eh || wb.byp_data !== ed) begin mismatched++; $display("[TB] FAIL bypass_outstage: got %b/%h expected %b/%h", wb.byp_hit, wb.byp_data, eh, ed); end
      wb.byp_src = 5'd0;
      #1;
      compared++; if (wb.byp_hit !== 1'b0) begin mismatched++; $display("[TB] FAIL bypass_x0: got %b expected 0", wb.byp_hit); end
      idle_inputs();
   endtask

   task automatic test_random();
      bit          pacc, lacc;
      logic        eh;
      logic [31:0] ed;
      do_reset();
      pacc = 1'b0;
      lacc = 1'b0;
      for (int c = 0; c < 800; c++) begin
         if (!wb.p_valid || pacc) begin
            wb.p_valid = ($urandom_range(0, 3) != 0);
            wb.p_dest  = 5'($urandom_range(0, 7));
            wb.p_data  = $urandom;
         end
         if (!wb.l_valid || lacc) begin
            wb.l_valid = ($urandom_range(0, 1) != 0);
            wb.l_dest  = 5'($urandom_range(0, 7));
            wb.l_data  = $urandom;
         end
         wb.byp_src = 5'($urandom_range(0, 8));
         #1;
         compared++; if (wb.p_ready !== !m_gl()) begin mismatched++; $display("[TB] FAIL rand_pready c%0d: got %b expected %b", c, wb.p_ready, !m_gl()); end
         compared++; if (wb.l_ready !== (mq.size() < DEPTH)) begin mismatched++; $display("[TB] FAIL rand_lready c%0d: got %b expected %b", c, wb.l_ready, (mq.size() < DEPTH)); end
         m_byp(wb.byp_src, eh, ed);
         compared++; if (wb.byp_hit !== eh || wb.byp_data !== ed) begin mismatched++; $display("[TB] FAIL rand_bypass c%0d: got %b/%h expected %b/%h", c, wb.byp_hit, wb.byp_data, eh, ed); end
         pacc = wb.p_valid && !m_gl();
         lacc = wb.l_valid && (mq.size() < DEPTH);
         tick();
         compared++; if (wb.writeEnable !== m_we || wb.dest !== m_dest || wb.writeData !== m_data) begin mismatched++; $display("[TB] FAIL rand_write c%0d: got %b/%0d/%h expected %b/%0d/%h", c, wb.writeEnable, wb.dest, wb.writeData, m_we, m_dest, m_data); end
         compared++; if (wb.pending !== m_pending()) begin mismatched++; $display("[TB] FAIL rand_pending c%0d: got %h expected %h", c, wb.pending, m_pending()); end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      model_reset();
      $display("[TB] start");
      test_reset();
      test_p_only();
      test_x0_drop();
      test_fifo_full();
      test_starvation();
      test_reset_midrun();
      test_bypass();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
